// File: rtl/uop_buffer.sv
// rtl/uop_buffer.sv - micro-op bundle buffer with power-on clear sequencer and 1-cycle registered read
// Optional macro UOP_BUF_BYPASS_EN: same-address read/write returns the incoming write data.
module uop_buffer #(
    parameter int UOP_BUF_SIZE  = 128,
    parameter int UOP_BUF_WIDTH = 72
) (
    input  logic                            clk,
    input  logic                            reset,
    input  logic                            wr_valid,
    output logic                            wr_ready,
    input  logic [$clog2(UOP_BUF_SIZE)-1:0] wr_addr,
    input  logic [UOP_BUF_WIDTH-1:0]        wr_data,
    input  logic                            rd_en,
    input  logic [$clog2(UOP_BUF_SIZE)-1:0] uop_addr,
    output logic [UOP_BUF_WIDTH-1:0]        uop,
    output logic                            uop_valid,
    output logic                            busy
);

    localparam int AW = $clog2(UOP_BUF_SIZE);
    localparam logic [AW-1:0] LAST_IDX = AW'(UOP_BUF_SIZE - 1);

    typedef enum logic {
        CLEAR = 1'b0,
        READY = 1'b1
    } state_t;

    state_t                   state_q;
    logic [AW-1:0]            clr_ptr_q;
    logic                     busy_q;
    logic                     wr_ready_q;
    logic [UOP_BUF_WIDTH-1:0] uop_q;
    logic [UOP_BUF_WIDTH-1:0] uop_d;
    logic                     uop_valid_q;
    logic                     wr_fire;
    logic                     rd_fire;

    logic [UOP_BUF_WIDTH-1:0] mem [UOP_BUF_SIZE];

    // wr_ready_q mirrors state_q == READY, so it doubles as the write gate
    assign wr_fire = wr_valid && wr_ready_q;
    assign rd_fire = rd_en && (state_q == READY);

    // clr_ptr holds at its terminal value once READY, so no second clear pass starts
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q    <= CLEAR;
            clr_ptr_q  <= '0;
            busy_q     <= 1'b1;
            wr_ready_q <= 1'b0;
        end else begin
            case (state_q)
                CLEAR: begin
                    if (clr_ptr_q == LAST_IDX) begin
                        state_q    <= READY;
                        busy_q     <= 1'b0;
                        wr_ready_q <= 1'b1;
                    end else begin
                        clr_ptr_q <= clr_ptr_q + AW'(1);
                    end
                end
                READY: begin
                    state_q    <= READY;
                    busy_q     <= 1'b0;
                    wr_ready_q <= 1'b1;
                end
                default: begin
                    state_q    <= CLEAR;
                    clr_ptr_q  <= '0;
                    busy_q     <= 1'b1;
                    wr_ready_q <= 1'b0;
                end
            endcase
        end
    end

    // Writes and clears are suppressed on a reset edge so a concurrent request leaves no trace
    always_ff @(posedge clk) begin
        if (!reset) begin
            if (state_q == CLEAR) begin
                mem[clr_ptr_q] <= '0;
            end else if (wr_fire) begin
                mem[wr_addr] <= wr_data;
            end
        end
    end

    always_comb begin
        uop_d = mem[uop_addr];
`ifdef UOP_BUF_BYPASS_EN
        if (wr_fire && (wr_addr == uop_addr)) begin
            uop_d = wr_data;
        end
`endif
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            uop_q       <= '0;
            uop_valid_q <= 1'b0;
        end else if (rd_fire) begin
            uop_q       <= uop_d;
            uop_valid_q <= 1'b1;
        end else begin
            uop_valid_q <= 1'b0;
        end
    end

    assign uop       = uop_q;
    assign uop_valid = uop_valid_q;
    assign busy      = busy_q;
    assign wr_ready  = wr_ready_q;

endmodule

// File: tb/tb_uop_buffer.sv
// tb/tb_uop_buffer.sv - directed self-checking bench for uop_buffer
module tb_uop_buffer;

    localparam int SIZE  = 128;
    localparam int WIDTH = 72;
    localparam int AW    = $clog2(SIZE);

    logic             clk = 1'b0;
    logic             reset;
    logic             wr_valid;
    logic             wr_ready;
    logic [AW-1:0]    wr_addr;
    logic [WIDTH-1:0] wr_data;
    logic             rd_en;
    logic [AW-1:0]    uop_addr;
    logic [WIDTH-1:0] uop;
    logic             uop_valid;
    logic             busy;

    int checks = 0;
    int errors = 0;

    localparam logic [WIDTH-1:0] B0 = 72'h01205021B01205021B;
    localparam logic [WIDTH-1:0] B1 = 72'h25270004B25270005B;
    localparam logic [WIDTH-1:0] B2 = 72'h25270004B00000000B;
    localparam logic [WIDTH-1:0] B3 = 72'h123456789ABCDEF012;
    localparam logic [WIDTH-1:0] BL = 72'hFEDCBA9876543210FF;

    always #5 clk = ~clk;

    uop_buffer #(.UOP_BUF_SIZE(SIZE), .UOP_BUF_WIDTH(WIDTH)) dut (
        .clk      (clk),
        .reset    (reset),
        .wr_valid (wr_valid),
        .wr_ready (wr_ready),
        .wr_addr  (wr_addr),
        .wr_data  (wr_data),
        .rd_en    (rd_en),
        .uop_addr (uop_addr),
        .uop      (uop),
        .uop_valid(uop_valid),
        .busy     (busy)
    );

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [WIDTH-1:0] obs, input logic [WIDTH-1:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    initial begin
        logic [WIDTH-1:0] exp_same;
        reset    = 1'b1;
        wr_valid = 1'b0;
        wr_addr  = '0;
        wr_data  = '0;
        rd_en    = 1'b0;
        uop_addr = '0;

        // one-cycle reset pulse, then a read held against the clear sequence
        step();
        chk("rst_uop", uop, '0);
        chk("rst_wr_ready", {71'd0, wr_ready}, 72'd0);
        reset    = 1'b0;
        rd_en    = 1'b1;
        uop_addr = AW'(5);
        for (int i = 0; i < SIZE; i++) begin
            chk("clr_busy", {71'd0, busy}, 72'd1);
            chk("clr_uop_valid", {71'd0, uop_valid}, 72'd0);
            step();
        end
        chk("ready_busy", {71'd0, busy}, 72'd0);
        chk("ready_wr_ready", {71'd0, wr_ready}, 72'd1);
        chk("ready_uop_valid_lag", {71'd0, uop_valid}, 72'd0);
        step();
        chk("first_rd_valid", {71'd0, uop_valid}, 72'd1);
        chk("first_rd_uop", uop, '0);

        // single write then read of entry 0
        rd_en = 1'b0; wr_valid = 1'b1; wr_addr = AW'(0); wr_data = B0;
        step();
        wr_valid = 1'b0; rd_en = 1'b1; uop_addr = AW'(0);
        step();
        chk("rd0_uop", uop, B0);
        chk("rd0_valid", {71'd0, uop_valid}, 72'd1);
        rd_en = 1'b0;
        step();
        chk("idle_valid", {71'd0, uop_valid}, 72'd0);
        chk("idle_uop_hold", uop, B0);

        // back-to-back reads of 0,1,2 and a repeated address
        wr_valid = 1'b1; wr_addr = AW'(1); wr_data = B1;
        step();
        wr_addr = AW'(2); wr_data = B2;
        step();
        wr_valid = 1'b0; rd_en = 1'b1; uop_addr = AW'(0);
        step();
        chk("b2b_0", uop, B0);
        chk("b2b_0_valid", {71'd0, uop_valid}, 72'd1);
        uop_addr = AW'(1);
        step();
        chk("b2b_1", uop, B1);
        chk("b2b_1_valid", {71'd0, uop_valid}, 72'd1);
        uop_addr = AW'(2);
        step();
        chk("b2b_2", uop, B2);
        chk("b2b_2_valid", {71'd0, uop_valid}, 72'd1);
        step();
        chk("b2b_2_again", uop, B2);
        chk("b2b_2_again_valid", {71'd0, uop_valid}, 72'd1);

        // concurrent write and read at different addresses
        wr_valid = 1'b1; wr_addr = AW'(3); wr_data = B3; uop_addr = AW'(1);
        step();
        chk("wr_rd_diff_rd", uop, B1);
        wr_valid = 1'b0; uop_addr = AW'(3);
        step();
        chk("wr_rd_diff_wr", uop, B3);

        // same-address write/read collision
        rd_en = 1'b0; wr_valid = 1'b1; wr_addr = AW'(7); wr_data = 72'hAA;
        step();
        rd_en = 1'b1; uop_addr = AW'(7); wr_data = 72'hBB;
`ifdef UOP_BUF_BYPASS_EN
        exp_same = 72'hBB;
`else
        exp_same = 72'hAA;
`endif
        step();
        chk("same_addr_collide", uop, exp_same);
        wr_valid = 1'b0;
        step();
        chk("same_addr_after", uop, 72'hBB);

        // top index
        rd_en = 1'b0; wr_valid = 1'b1; wr_addr = AW'(SIZE - 1); wr_data = BL;
        step();
        wr_valid = 1'b0; rd_en = 1'b1; uop_addr = AW'(SIZE - 1);
        step();
        chk("top_index", uop, BL);

        // reset in READY with concurrent read and write, then reset again mid-clear
        reset = 1'b1; wr_valid = 1'b1; wr_addr = AW'(9); wr_data = 72'h55; uop_addr = AW'(0);
        step();
        chk("rst_ready_uop", uop, '0);
        chk("rst_ready_valid", {71'd0, uop_valid}, 72'd0);
        chk("rst_ready_busy", {71'd0, busy}, 72'd1);
        reset = 1'b0; wr_valid = 1'b0;
        for (int i = 0; i < 60; i++) step();
        chk("mid_clr_busy", {71'd0, busy}, 72'd1);
        reset = 1'b1;
        step();
        reset = 1'b0; wr_valid = 1'b1; wr_addr = AW'(9); wr_data = 72'hDEAD; rd_en = 1'b1;
        for (int i = 0; i < SIZE; i++) begin
            chk("reclr_busy", {71'd0, busy}, 72'd1);
            chk("reclr_wr_ready", {71'd0, wr_ready}, 72'd0);
            chk("reclr_uop_valid", {71'd0, uop_valid}, 72'd0);
            step();
        end
        wr_valid = 1'b0;
        chk("reclr_done", {71'd0, busy}, 72'd0);
        uop_addr = AW'(9);
        step();
        chk("dropped_wr", uop, '0);
        chk("dropped_wr_valid", {71'd0, uop_valid}, 72'd1);
        uop_addr = AW'(0);
        step();
        chk("recleared_0", uop, '0);
        uop_addr = AW'(SIZE - 1);
        step();
        chk("recleared_top", uop, '0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/uop_buffer.md
UOP_BUFFER -- requirements
Module: uop_buffer

Interface
REQ-001 Parameter UOP_BUF_SIZE, default 128 (from defines.inc): number of bundle entries.
REQ-002 Parameter UOP_BUF_WIDTH, default 72 (from defines.inc): bundle width, two 36-bit slots.
REQ-003 clk  input  1  sole clock; all state updates on rising edge.
REQ-004 reset  input  1  synchronous, active-high reset.
REQ-005 wr_valid  input  1  write request.
REQ-006 wr_ready  output  1  buffer accepts writes.
REQ-007 wr_addr  input  $clog2(UOP_BUF_SIZE)  write entry index.
REQ-008 wr_data  input  UOP_BUF_WIDTH  bundle to store.
REQ-009 rd_en  input  1  read request from microcode_unit.
REQ-010 uop_addr  input  $clog2(UOP_BUF_SIZE)  read entry index, driven by microcode_unit.
REQ-011 uop  output  UOP_BUF_WIDTH  registered read bundle to microcode_unit.
REQ-012 uop_valid  output  1  uop holds data for the previous accepted read.
REQ-013 busy  output  1  clear sequence in progress.

Function
REQ-014 Bundle layout SHALL be slot1 = [71:36] and slot0 = [35:0]; each slot is instr[35:4], branch_tag[3:2], flag[1], flag[0]; the buffer stores it opaquely.
REQ-015 The FSM SHALL have two states: CLEAR and READY.
REQ-016 In CLEAR, one entry per cycle SHALL be zeroed at clr_ptr, starting at 0 and incrementing.
REQ-017 CLEAR SHALL go to READY on the cycle after entry UOP_BUF_SIZE-1 is zeroed, giving exactly UOP_BUF_SIZE clear cycles.
REQ-018 READY SHALL remain until reset; there is no other transition.
REQ-019 busy SHALL equal (state == CLEAR); wr_ready SHALL equal (state == READY).
REQ-020 A write SHALL occur when wr_valid && wr_ready: mem[wr_addr] <= wr_data at that edge.
REQ-021 wr_valid while wr_ready is low SHALL be dropped, with no side effect.
REQ-022 A read SHALL be accepted when rd_en && state == READY; uop <= mem[uop_addr] and uop_valid <= 1 at that edge (1-cycle latency).
REQ-023 When no read is accepted, uop SHALL hold its value and uop_valid SHALL go to 0.
REQ-024 Back-to-back reads SHALL be supported at one per cycle, including the same address in consecutive cycles.
REQ-025 A simultaneous write and read to different addresses SHALL both complete in the same cycle.
REQ-026 A simultaneous write and read to the same address SHALL follow REQ-034.
REQ-027 rd_en during CLEAR SHALL be ignored: uop_valid = 0 and uop is unchanged.
REQ-028 uop_addr and wr_addr SHALL span the full index range with no wrap checks; the clr_ptr terminal value SHALL NOT wrap into a second clear pass.

Reset
REQ-029 reset asserted at a rising edge SHALL set state = CLEAR, clr_ptr = 0, uop = 0, uop_valid = 0, busy = 1 (next cycle), and wr_ready = 0.
REQ-030 reset asserted mid-CLEAR SHALL restart the clear from entry 0.
REQ-031 reset asserted in READY SHALL discard any concurrent read or write at that edge and begin a full re-clear.
REQ-032 Memory contents are undefined only until the clear sequence completes; after READY every entry reads 0 until written.

Configuration
REQ-033 The macro UOP_BUF_BYPASS_EN SHALL select same-address read/write behaviour.
REQ-034 With UOP_BUF_BYPASS_EN defined, a same-cycle read of wr_addr SHALL return wr_data (write-first).
REQ-035 Without UOP_BUF_BYPASS_EN, a same-cycle read of wr_addr SHALL return the prior contents (read-first); the new data is visible from the next read.

Verification
REQ-036 Pulse reset one cycle, then hold rd_en=1 with uop_addr=5 -> busy=1 and uop_valid=0 for 128 cycles; then uop_valid=1 and uop=0.
REQ-037 After READY, write addr 0 = 'h01205021B01205021B, then read addr 0 -> next cycle uop='h01205021B01205021B, uop_valid=1.
REQ-038 Write addr 1 = 'h25270004B25270005B and addr 2 = 'h25270004B00000000B; read 0,1,2 on consecutive cycles -> matching bundles on 3 consecutive cycles, uop_valid held at 1.
REQ-039 Write addr 7 = 'hAA followed by a same-cycle write of 'hBB to addr 7 with read of addr 7 -> uop='hBB with UOP_BUF_BYPASS_EN, 'hAA without; the following read returns 'hBB in both builds.
REQ-040 Assert reset at clear cycle 60 -> busy stays 1 for 128 further cycles; wr_valid during that time is dropped (the entry still reads 0 after READY).
